// File: rtl/vga_pkg.sv
// Shared constants and grant encoding for the framebuffer memory arbiter.
//   ADDR_W / DATA_W    : framebuffer address and pixel widths
//   FRAME_PIXELS       : pixels per frame; the prefetch address stops here
//   FIFO_DEPTH         : prefetch entries
//   LOW_WATER          : below this occupancy a fetch is urgent and beats draw
//   grant_e            : which requester owns the SRAM port this cycle
package vga_pkg;
  localparam int ADDR_W       = 19;
  localparam int DATA_W       = 8;
  localparam int FRAME_PIXELS = 307200;
  localparam int FIFO_DEPTH   = 4;
  localparam int LOW_WATER    = 2;

  typedef enum logic [1:0] {
    GRANT_IDLE  = 2'd0,
    GRANT_FETCH = 2'd1,
    GRANT_DRAW  = 2'd2
  } grant_e;
endpackage

// File: rtl/frame_mem_arbiter_if.sv
// Draw-port and SRAM-port bundle of the framebuffer arbiter.
//   master : the arbiter (takes draw requests, drives the SRAM)
//   slave  : the environment (drawing requester plus the SRAM itself)
//   draw side : drawReq/drawWe/drawAddr/drawWData in, drawAck/drawRData/drawRValid out
//   mem side  : memEn/memWe/memAddr/memWData out, memRData in (one clk read latency)
interface frame_mem_arbiter_if #(
  parameter int ADDR_W = vga_pkg::ADDR_W,
  parameter int DATA_W = vga_pkg::DATA_W
);
  logic              drawReq;
  logic              drawWe;
  logic [ADDR_W-1:0] drawAddr;
  logic [DATA_W-1:0] drawWData;
  logic              drawAck;
  logic [DATA_W-1:0] drawRData;
  logic              drawRValid;
  logic              memEn;
  logic              memWe;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memWData;
  logic [DATA_W-1:0] memRData;

  modport master (
    input  drawReq, drawWe, drawAddr, drawWData, memRData,
    output drawAck, drawRData, drawRValid, memEn, memWe, memAddr, memWData
  );

  modport slave (
    output drawReq, drawWe, drawAddr, drawWData, memRData,
    input  drawAck, drawRData, drawRValid, memEn, memWe, memAddr, memWData
  );
endinterface

// File: rtl/pixel_fifo.sv
// Synchronous prefetch FIFO for display pixels.
//   clk, rst (async, active-high), flush (sync, dominates push/pop)
//   push/pushData : write an entry; pop : drop the head entry
//   headData      : current head entry (valid when !empty)
//   count, empty  : stored-entry count and empty flag
module pixel_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [DATA_W-1:0]          pushData,
  input  logic                       pop,
  output logic [DATA_W-1:0]          headData,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty
);
  import vga_pkg::*;

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  wrPtr_r;
  logic [PTR_W-1:0]  rdPtr_r;
  logic [CNT_W-1:0]  count_r;
  logic              full_s;
  logic              doPop_s;
  logic              doPush_s;

  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(DEPTH - 1)) begin
      nextPtr = '0;
    end else begin
      nextPtr = ptr + PTR_W'(1);
    end
  endfunction

  assign empty    = (count_r == CNT_W'(0));
  assign full_s   = (count_r == CNT_W'(DEPTH));
  assign doPop_s  = pop && !empty;
  // A full FIFO can still accept a push when the head leaves in the same cycle.
  assign doPush_s = push && (!full_s || doPop_s);
  assign headData = mem_r[rdPtr_r];
  assign count    = count_r;

  // Entry storage: written on push, no reset needed (guarded by count).
  always_ff @(posedge clk) begin
    if (doPush_s && !flush) begin
      mem_r[wrPtr_r] <= pushData;
    end
  end

  // Pointers and occupancy count; flush empties the FIFO outright.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_r <= '0;
      rdPtr_r <= '0;
      count_r <= '0;
    end else if (flush) begin
      wrPtr_r <= '0;
      rdPtr_r <= '0;
      count_r <= '0;
    end else begin
      if (doPush_s) wrPtr_r <= nextPtr(wrPtr_r);
      if (doPop_s)  rdPtr_r <= nextPtr(rdPtr_r);
      case ({doPush_s, doPop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end
endmodule

// File: rtl/frame_mem_arbiter.sv
// Arbitrates one single-port framebuffer SRAM between display prefetch and a
// drawing requester, and feeds the display one pixel per pixelTick.
//   clk, rst (async, active-high)
//   pixelTick, frameStart, displayActive : display timing inputs
//   pixelOut (registered), underflow (sticky) : display outputs
//   bus (master) : draw request/response and SRAM port
module frame_mem_arbiter #(
  parameter int ADDR_W       = vga_pkg::ADDR_W,
  parameter int DATA_W       = vga_pkg::DATA_W,
  parameter int FIFO_DEPTH   = vga_pkg::FIFO_DEPTH,
  parameter int LOW_WATER    = vga_pkg::LOW_WATER,
  parameter int FRAME_PIXELS = vga_pkg::FRAME_PIXELS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pixelTick,
  input  logic                frameStart,
  input  logic                displayActive,
  output logic [DATA_W-1:0]   pixelOut,
  output logic                underflow,
  frame_mem_arbiter_if.master bus
);
  import vga_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int OCC_W = CNT_W + 1;

  grant_e            grant_s;
  logic [ADDR_W-1:0] fetchAddr_r;
  logic              inFlight_r;
  logic              drawRValid_r;
  logic [DATA_W-1:0] drawRDataHold_r;
  logic [DATA_W-1:0] pixelOut_r;
  logic              underflow_r;
  logic [DATA_W-1:0] fifoHead_s;
  logic [CNT_W-1:0]  fifoCount_s;
  logic              fifoEmpty_s;
  logic [OCC_W-1:0]  occupancy_s;
  logic              fetchOk_s;
  logic              popReq_s;
  logic              fifoPush_s;

  // The fetch still in the SRAM pipeline already owns a FIFO slot.
  assign occupancy_s = OCC_W'(fifoCount_s) + OCC_W'(inFlight_r);
  // Prefetch parks at end of frame and never runs during the frameStart cycle.
  assign fetchOk_s   = !frameStart && (fetchAddr_r != ADDR_W'(FRAME_PIXELS));
  assign popReq_s    = pixelTick && displayActive && !frameStart;
  assign fifoPush_s  = inFlight_r && !frameStart;

  pixel_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (frameStart),
    .push     (fifoPush_s),
    .pushData (bus.memRData),
    .pop      (popReq_s),
    .headData (fifoHead_s),
    .count    (fifoCount_s),
    .empty    (fifoEmpty_s)
  );

  // Grant selection: urgent fetch, then draw, then opportunistic fetch.
  always_comb begin
    grant_s = GRANT_IDLE;
    if (rst) begin
      grant_s = GRANT_IDLE;
    end else if (fetchOk_s && (occupancy_s < OCC_W'(LOW_WATER))) begin
      grant_s = GRANT_FETCH;
    end else if (bus.drawReq) begin
      grant_s = GRANT_DRAW;
    end else if (fetchOk_s && (occupancy_s < OCC_W'(FIFO_DEPTH))) begin
      grant_s = GRANT_FETCH;
    end else begin
      grant_s = GRANT_IDLE;
    end
  end

  // SRAM command and draw acknowledge decoded straight from the grant.
  always_comb begin
    bus.memEn    = 1'b0;
    bus.memWe    = 1'b0;
    bus.memAddr  = '0;
    bus.memWData = '0;
    bus.drawAck  = 1'b0;
    case (grant_s)
      GRANT_FETCH: begin
        bus.memEn   = 1'b1;
        bus.memAddr = fetchAddr_r;
      end
      GRANT_DRAW: begin
        bus.memEn    = 1'b1;
        bus.memWe    = bus.drawWe;
        bus.memAddr  = bus.drawAddr;
        bus.memWData = bus.drawWData;
        bus.drawAck  = 1'b1;
      end
      default: begin
        bus.memEn = 1'b0;
      end
    endcase
  end

  // Read data is live on memRData in the valid cycle, then held locally.
  assign bus.drawRValid = drawRValid_r;
  assign bus.drawRData  = drawRValid_r ? bus.memRData : drawRDataHold_r;

  // Prefetch address, in-flight fetch marker and draw-read return tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetchAddr_r     <= '0;
      inFlight_r      <= 1'b0;
      drawRValid_r    <= 1'b0;
      drawRDataHold_r <= '0;
    end else begin
      if (frameStart) begin
        fetchAddr_r <= '0;
      end else if (grant_s == GRANT_FETCH) begin
        fetchAddr_r <= fetchAddr_r + ADDR_W'(1);
      end
      inFlight_r   <= (grant_s == GRANT_FETCH);
      drawRValid_r <= (grant_s == GRANT_DRAW) && !bus.drawWe;
      if (drawRValid_r) begin
        drawRDataHold_r <= bus.memRData;
      end
    end
  end

  // Display output: pop on active ticks, blank when inactive, sticky underflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pixelOut_r  <= '0;
      underflow_r <= 1'b0;
    end else if (pixelTick) begin
      if (popReq_s) begin
        if (fifoEmpty_s) begin
          pixelOut_r  <= '0;
          underflow_r <= 1'b1;
        end else begin
          pixelOut_r <= fifoHead_s;
        end
      end else if (!displayActive) begin
        pixelOut_r <= '0;
      end
    end
  end

  assign pixelOut  = pixelOut_r;
  assign underflow = underflow_r;
endmodule

// File: doc/frame_mem_arbiter.md
FRAME_MEM_ARBITER -- requirements
Module: frame_mem_arbiter

Interface
REQ-001 Parameters: ADDR_W, default 19, framebuffer address width; DATA_W, default 8, pixel width; FIFO_DEPTH, default 4, prefetch entries; LOW_WATER, default 2, fetch-urgent threshold; FRAME_PIXELS, default 307200, pixels per frame.
REQ-002 Ports: clk in 1, system clock; rst in 1, reset, asynchronous, active-high.
REQ-003 Ports: pixelTick in 1, pixel-rate strobe (one clk in two); frameStart in 1, one-cycle pulse at frame start; displayActive in 1, visible-region flag.
REQ-004 Ports: pixelOut out DATA_W, registered display pixel; underflow out 1, sticky FIFO-empty-on-pop flag.
REQ-005 Ports: drawReq in 1, drawWe in 1, drawAddr in ADDR_W, drawWData in DATA_W; drawAck out 1, op-issued pulse; drawRData out DATA_W, drawRValid out 1, read-return pulse.
REQ-006 Ports: memEn out 1, memWe out 1, memAddr out ADDR_W, memWData out DATA_W, memRData in DATA_W (single-port synchronous SRAM, read data valid one clk after memEn with memWe=0).

Function
REQ-007 At most one memory op SHALL issue per clk; memEn=0 in cycles with no grant.
REQ-008 Occupancy SHALL count stored entries plus the in-flight fetch read.
REQ-009 Grant per cycle: FETCH if occupancy < LOW_WATER; else DRAW if drawReq; else FETCH if occupancy < FIFO_DEPTH; else idle.
REQ-010 FETCH SHALL be suppressed once fetchAddr = FRAME_PIXELS (no wrap until frameStart).
REQ-011 FETCH: memEn=1, memWe=0, memAddr=fetchAddr, fetchAddr increments; memRData SHALL be pushed into the FIFO the following cycle.
REQ-012 DRAW: memEn=1, memWe=drawWe, memAddr=drawAddr, memWData=drawWData, drawAck=1 the same cycle (combinational from grant).
REQ-013 DRAW read: drawRValid=1 and drawRData=memRData exactly one cycle after drawAck; drawRData holds until the next draw read.
REQ-014 Requester SHALL hold drawReq and operands stable until drawAck; drawReq may stay high for back-to-back ops.
REQ-015 Pop: on pixelTick & displayActive, head entry SHALL load pixelOut; if FIFO empty, pixelOut<=0 and underflow<=1.
REQ-016 When displayActive=0, pixelOut SHALL be 0 at the next pixelTick; no pop.
REQ-017 Push and pop in the same cycle SHALL both take effect; occupancy unchanged.
REQ-018 frameStart SHALL, in that cycle, reset fetchAddr to 0, flush the FIFO, discard any in-flight fetch return, and override a coincident pop; no FETCH issues in the frameStart cycle; a DRAW may.
REQ-019 underflow SHALL clear only on rst.

Reset
REQ-020 On rst: pixelOut=0, underflow=0, drawAck=0, drawRValid=0, drawRData=0, memEn=0, memWe=0, memAddr=0, memWData=0, fetchAddr=0, FIFO empty, no in-flight op.
REQ-021 rst mid-operation SHALL abandon any in-flight read with no drawRValid or push after release.

Structure
REQ-022 ADDR_W, DATA_W, FRAME_PIXELS and grant encoding (IDLE, FETCH, DRAW) SHALL live in shared package vga_pkg.
REQ-023 Prefetch storage SHALL be sub-module pixel_fifo (synchronous, FIFO_DEPTH entries, push/pop/count).

Verification
REQ-024 Reset, frameStart, drawReq=0, displayActive=0 -> fetches to addrs 0..3 in first 4 cycles, then memEn=0; pixelOut=0.
REQ-025 FIFO full, drawReq=1 write addr 0x100 data 0xA5 -> drawAck same cycle, memWe=1, memAddr=0x100, memWData=0xA5.
REQ-026 Draw read addr 0x10 holding 0x3C with occupancy>=LOW_WATER -> drawAck, then drawRValid=1, drawRData=0x3C next cycle.
REQ-027 displayActive=1, pixelTick every 2 clk, drawReq held 1 for 640 pixels -> underflow stays 0, pixelOut sequence matches memory 0..639, draw gets ~1 of 2 cycles.
REQ-028 displayActive=1 before any fetch after reset, pixelTick -> pixelOut=0, underflow=1 and stays 1.
REQ-029 frameStart coincident with pop and in-flight fetch -> no pop, FIFO empty next cycle, next FETCH addr 0; fetchAddr stops at 307200 without frameStart.
